// File: rtl/bcd_counter_pkg.sv
// rtl/bcd_counter_pkg.sv - shared constants, digit-width helper and digit array type for the BCD up counter
//
// Contents:
//   DEF_RADIX, DEF_DIGITS : default modulus per digit and default number of digits
//   digit_width()         : number of bits needed to hold one digit of a given radix
//   digit_arr_t           : packed DEF_DIGITS x DEF_DW array, digit 0 least significant
package bcd_counter_pkg;

   localparam int DEF_RADIX  = 10;
   localparam int DEF_DIGITS = 2;

   // A radix of 2 still needs one bit, which $clog2(2) already gives.
   // The guard covers nonsensical radices below 2, so a width of 0 never appears.
   function automatic int digit_width(input int radix);
      if (radix <= 2)
         return 1;
      return $clog2(radix);
   endfunction

   localparam int DEF_DW = digit_width(DEF_RADIX);

   typedef logic [DEF_DIGITS-1:0][DEF_DW-1:0] digit_arr_t;

endpackage

// File: rtl/bcd_digit_counter.sv
// rtl/bcd_digit_counter.sv - one modulo-RADIX up-counting digit stage with clear, clamped load and carry enable
//
// Ports:
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset
//   clr          : synchronous clear to zero
//   load         : synchronous load of load_digit (clamped to RADIX-1)
//   load_digit   : value to load
//   carry_in     : increment enable from the carry chain
//   digit        : current digit value
//   at_max       : digit equals RADIX-1
//   load_clamped : load_digit is out of range (meaningful while load is high)
module bcd_digit_counter
   import bcd_counter_pkg::*;
#(
   parameter int RADIX = DEF_RADIX,
   parameter int DW    = digit_width(RADIX)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          load,
   input  logic [DW-1:0] load_digit,
   input  logic          carry_in,
   output logic [DW-1:0] digit,
   output logic          at_max,
   output logic          load_clamped
);

   localparam logic [DW-1:0] MAX_V   = DW'(RADIX - 1);
   // One extra bit so a power-of-two radix is representable for the compare.
   localparam logic [DW:0]   RADIX_W = (DW + 1)'(RADIX);

   logic [DW-1:0] load_safe;

   assign at_max       = (digit == MAX_V);
   // For a power-of-two radix every DW-bit value is in range, so this is constant 0.
   assign load_clamped = ({1'b0, load_digit} >= RADIX_W);
   assign load_safe    = load_clamped ? MAX_V : load_digit;

   always_ff @(posedge clk) begin
      if (rst) begin
         digit <= '0;
      end else if (clr) begin
         digit <= '0;
      end else if (load) begin
         digit <= load_safe;
      end else if (carry_in) begin
         digit <= at_max ? '0 : digit + DW'(1);
      end
   end

endmodule

// File: rtl/bcd_up_counter_cascade.sv
// rtl/bcd_up_counter_cascade.sv - cascadable DIGITS x modulo-RADIX up counter with look-ahead tc and sticky overflow
//
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   clr      : synchronous clear of count, ovf and load_err
//   load     : synchronous parallel load from load_val; en ignored that cycle
//   load_val : digit i at [i*DW +: DW], digit 0 least significant
//   en       : count enable, one increment per cycle
//   count    : current count, same packing as load_val
//   tc       : combinational, en high and every digit at RADIX-1
//   ovf      : sticky, set on full wrap, cleared by clr or rst
//   load_err : one-cycle pulse after a load that had an out-of-range digit
module bcd_up_counter_cascade
   import bcd_counter_pkg::*;
#(
   parameter  int RADIX  = DEF_RADIX,
   parameter  int DIGITS = DEF_DIGITS,
   localparam int DW     = digit_width(RADIX)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 load,
   input  logic [DIGITS*DW-1:0] load_val,
   input  logic                 en,
   output logic [DIGITS*DW-1:0] count,
   output logic                 tc,
   output logic                 ovf,
   output logic                 load_err
);

   logic [DIGITS-1:0] at_max;
   logic [DIGITS-1:0] clamped;
   // carry[i] enables digit i; carry[DIGITS] is en with every digit at max.
   logic [DIGITS:0]   carry;

   assign carry[0] = en;

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      assign carry[i+1] = carry[i] & at_max[i];

      bcd_digit_counter #(
         .RADIX (RADIX),
         .DW    (DW)
      ) u_digit (
         .clk          (clk),
         .rst          (rst),
         .clr          (clr),
         .load         (load),
         .load_digit   (load_val[i*DW +: DW]),
         .carry_in     (carry[i]),
         .digit        (count[i*DW +: DW]),
         .at_max       (at_max[i]),
         .load_clamped (clamped[i])
      );
   end

   // Same-cycle look-ahead so a downstream counter can use tc directly as its en.
   assign tc = carry[DIGITS];

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         ovf      <= 1'b0;
         load_err <= 1'b0;
      end else if (load) begin
         load_err <= |clamped;
      end else begin
         load_err <= 1'b0;
         if (tc)
            ovf <= 1'b1;
      end
   end

endmodule

// File: doc/bcd_up_counter_cascade.md
Name: bcd_up_counter_cascade

Overview:
- Cascadable modulo-RADIX up counter: DIGITS stages, each counting 0..RADIX-1, with ripple-enable carry between stages.
- Counts in the opposite direction to the team's down counters; used for event tallies, timestamp digits and display drivers.
- Supports synchronous clear, parallel load and count enable. Provides a terminal-count look-ahead and a sticky overflow flag.

Parameters:
- RADIX, 10, modulus of each digit stage; must be >= 2.
- DIGITS, 2, number of cascaded digit stages; must be >= 1.
- DW, $clog2(RADIX), derived width of one digit; not overridden.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- clr  input  1  synchronous clear of count and overflow.
- load  input  1  synchronous parallel load from load_val.
- load_val  input  DIGITS*DW  digit i occupies bits [i*DW +: DW]; digit 0 is least significant.
- en  input  1  count enable; one increment per cycle while high.
- count  output  DIGITS*DW  current count, same packing as load_val.
- tc  output  1  combinational; en high and all digits equal RADIX-1.
- ovf  output  1  sticky overflow flag, registered.
- load_err  output  1  registered one-cycle pulse: a loaded digit was out of range.

Behaviour:
- Reset values on rising clk edge with rst=1: count=0, ovf=0, load_err=0.
- tc is combinational and evaluates to 0 while count=0.
- Priority per edge: rst > clr > load > en.
- clr: count=0, ovf=0, load_err=0.
- load:
  - each digit of count takes load_val digit i.
  - any digit >= RADIX is clamped to RADIX-1, and load_err=1 next cycle.
  - otherwise load_err=0.
  - ovf is unchanged and en is ignored that cycle.
- en with no higher-priority event:
  - digit 0 increments.
  - digit i (i>0) increments only if all digits below it equal RADIX-1 (carry-enable chain).
  - a digit at RADIX-1 that increments wraps to 0.
- Full wrap: if all digits equal RADIX-1 and en=1, the next count is all zeros and ovf is set to 1 and stays set until clr or rst.
- en=0 with no clr/load/rst: count holds; load_err clears to 0.
- Latency: count reflects load/clr/increment one cycle after the sampling edge.
- tc is valid in the same cycle as en, so a downstream cascade can use it as its enable without extra delay.
- Reset mid-operation: takes effect at the next edge regardless of en/load/clr.
- Non-power-of-two RADIX: digit registers never hold values >= RADIX after any operation.
- Power-of-two RADIX: clamping is unreachable and load_err stays 0.

Decomposition:
- Package bcd_counter_pkg holds:
  - default RADIX and DIGITS constants.
  - a function computing digit width.
  - a typedef for a packed DIGITS x DW digit array.
- Sub-module bcd_digit_counter implements one stage:
  - inputs: clk, rst, clr, load, load_digit, carry_in.
  - outputs: digit, at_max, load_clamped.
- The top instantiates DIGITS stages with a generate loop and chains carry_in(i) = en & at_max(0..i-1).
- The top owns ovf, load_err and tc.

Test Plan (RADIX=10, DIGITS=2, values as decimal digit pairs):
- Reset: rst=1 for 2 cycles with en=1 -> count=00, ovf=0, tc=0, load_err=0.
- Full count: from 00, en=1 for 99 cycles -> count=99 and tc=1. 100th edge -> count=00, ovf=1. One more cycle -> count=01, ovf still 1.
- Load then count: load=1, load_val=47 -> next cycle count=47, load_err=0. Then en=1 for 3 edges -> 50 (carry into digit 1 at 49->50).
- Out-of-range load: load_val digits {3, 12} (digit 0 = 12) -> count=39, load_err=1 for exactly one cycle. Then en=0 -> load_err=0.
- Priority: at count=55, assert clr, load (load_val=72) and en together -> count=00, ovf=0. Assert load and en together -> count=72, no increment.
- Reset mid-operation: counting with en=1 at count=63, ovf=1, rst=1 for one cycle -> count=00, ovf=0. Counting resumes 01, 02 after rst falls.
